// File: rtl/multiplier_datapath_tainttrack_pkg.sv
// mult_taint_pkg: shared widths and the carry-chain taint helper for the taint-tracking multiplier
package mult_taint_pkg;
  localparam int WIDTH = 4;
  localparam int RS_WIDTH = 2 * WIDTH + 1;
  function automatic logic [WIDTH:0] carry_taint(input logic [WIDTH-1:0] a_t, input logic [WIDTH-1:0] b_t);
    logic [WIDTH:0] t;
    t[0] = a_t[0] | b_t[0];
    for (int i = 1; i < WIDTH; i++) t[i] = t[i-1] | a_t[i] | b_t[i];
    t[WIDTH] = t[WIDTH-1];
    return t;
  endfunction
endpackage

// File: rtl/multiplier_datapath_tainttrack_if.sv
// multiplier_datapath_tainttrack_if: operands, strobes and their taints from the FSM (master); MR, product and valid back (slave)
interface multiplier_datapath_tainttrack_if #(parameter int WIDTH = mult_taint_pkg::WIDTH);
  logic [WIDTH-1:0] multiplicand, multiplicand_t, multiplier, multiplier_t;
  logic mdld, mdld_t, mrld, mrld_t, rsclear, rsclear_t, rsload, rsload_t, rsshr, rsshr_t, productDone, productDone_t;
  logic [WIDTH-1:0] multiplierReg, multiplierReg_t;
  logic [2*WIDTH-1:0] product, product_t;
  logic product_valid, product_valid_t;
  modport master(
    output multiplicand, multiplicand_t, multiplier, multiplier_t,
    output mdld, mdld_t, mrld, mrld_t, rsclear, rsclear_t, rsload, rsload_t, rsshr, rsshr_t, productDone, productDone_t,
    input multiplierReg, multiplierReg_t, product, product_t, product_valid, product_valid_t
  );
  modport slave(
    input multiplicand, multiplicand_t, multiplier, multiplier_t,
    input mdld, mdld_t, mrld, mrld_t, rsclear, rsclear_t, rsload, rsload_t, rsshr, rsshr_t, productDone, productDone_t,
    output multiplierReg, multiplierReg_t, product, product_t, product_valid, product_valid_t
  );
endinterface

// File: rtl/multiplier_datapath_tainttrack_taint_adder.sv
// taint_adder: W+W -> W+1 bit sum (a, b in; sum out) with carry-chain conservative taint (a_t, b_t in; sum_t out)
import mult_taint_pkg::*;
module taint_adder (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] a_t,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] b_t,
  output logic [WIDTH:0]   sum,
  output logic [WIDTH:0]   sum_t
);
  assign sum = {1'b0, a} + {1'b0, b};
  assign sum_t = carry_taint(a_t, b_t);
endmodule

// File: rtl/multiplier_datapath_tainttrack.sv
// multiplier_datapath_tainttrack: MD/MR/RS shift-add datapath with shadow taint (clk, rst, bus slave: strobes in, MR/product/valid out)
import mult_taint_pkg::*;
module multiplier_datapath_tainttrack (
  input logic clk,
  input logic rst,
  multiplier_datapath_tainttrack_if.slave bus
);
  logic [WIDTH-1:0] md, md_t, mr, mr_t;
  logic [RS_WIDTH-1:0] rs, rs_t, rs_n, rs_t_n;
  logic [WIDTH:0] sum, sum_t;
  logic pv, pv_t;
  taint_adder u_add (
    .a(rs[2*WIDTH-1:WIDTH]),
    .a_t(rs_t[2*WIDTH-1:WIDTH]),
    .b(md),
    .b_t(md_t),
    .sum(sum),
    .sum_t(sum_t)
  );
  always_comb begin
    rs_n = bus.rsclear ? '0 : bus.rsload ? {sum, rs[WIDTH-1:0]} : bus.rsshr ? rs >> 1 : rs;
    rs_t_n = (bus.rsclear_t | bus.rsload_t | bus.rsshr_t) ? '1 :
             bus.rsclear ? '0 : bus.rsload ? {sum_t, rs_t[WIDTH-1:0]} : bus.rsshr ? rs_t >> 1 : rs_t;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      md <= '0;
      md_t <= '0;
      mr <= '0;
      mr_t <= '0;
      rs <= '0;
      rs_t <= '0;
      pv <= 1'b0;
      pv_t <= 1'b0;
    end else begin
      md <= bus.mdld ? bus.multiplicand : md;
      md_t <= bus.mdld_t ? '1 : bus.mdld ? bus.multiplicand_t : md_t;
      mr <= bus.mrld ? bus.multiplier : mr;
      mr_t <= bus.mrld_t ? '1 : bus.mrld ? bus.multiplier_t : mr_t;
      rs <= rs_n;
      rs_t <= rs_t_n;
      pv <= bus.productDone;
      pv_t <= bus.productDone_t;
    end
  end
  assign bus.multiplierReg = mr;
  assign bus.multiplierReg_t = mr_t;
  assign bus.product = rs[2*WIDTH-1:0];
  assign bus.product_t = rs_t[2*WIDTH-1:0];
  assign bus.product_valid = pv;
  assign bus.product_valid_t = pv_t;
endmodule

// File: tb/tb_multiplier_datapath_tainttrack.sv
// tb_multiplier_datapath_tainttrack: scoreboard bench acting as the control FSM with a shift-add reference model
module tb_multiplier_datapath_tainttrack;
  localparam logic [5:0] MDLD = 6'b100000, MRLD = 6'b010000, CLR = 6'b001000, LD = 6'b000100, SHR = 6'b000010, DONE = 6'b000001;
  typedef struct {
    logic [7:0] p;
    logic [7:0] pt;
    logic vt;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int mismatched = 0;
  exp_t exp_q[$];
  multiplier_datapath_tainttrack_if bus ();
  multiplier_datapath_tainttrack dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  function automatic exp_t model(input int md, input int mdt, input int mr, input bit ctl);
    int t;
    int u;
    exp_t e;
    t = 0;
    for (int n = 0; n < 4; n++) begin
      t = t >> 1;
      if (((mr >> n) & 1) == 1) begin
        u = ((t >> 4) & 15) | mdt;
        t = (t & 15) | ((u == 0) ? 0 : ((32 - (u & -u)) << 4));
      end
    end
    t = t >> 1;
    e.p = 8'(md * mr);
    e.pt = ctl ? 8'hFF : 8'(t);
    e.vt = ctl;
    return e;
  endfunction
  task automatic step(input logic [5:0] s, input logic [5:0] t);
    {bus.mdld, bus.mrld, bus.rsclear, bus.rsload, bus.rsshr, bus.productDone} = s;
    {bus.mdld_t, bus.mrld_t, bus.rsclear_t, bus.rsload_t, bus.rsshr_t, bus.productDone_t} = t;
    @(posedge clk);
    #1;
    {bus.mdld, bus.mrld, bus.rsclear, bus.rsload, bus.rsshr, bus.productDone} = '0;
    {bus.mdld_t, bus.mrld_t, bus.rsclear_t, bus.rsload_t, bus.rsshr_t, bus.productDone_t} = '0;
  endtask
  task automatic run_mult(input int md, input int mdt, input int mr, input int mrt, input bit ctl);
    bus.multiplicand = 4'(md);
    bus.multiplicand_t = 4'(mdt);
    bus.multiplier = 4'(mr);
    bus.multiplier_t = 4'(mrt);
    step(MDLD | MRLD | CLR, '0);
    chk("mr_reg", {12'h0, bus.multiplierReg}, 16'(mr));
    chk("mr_reg_t", {12'h0, bus.multiplierReg_t}, 16'(mrt));
    for (int n = 0; n < 4; n++) begin
      step(SHR, '0);
      if (((mr >> n) & 1) == 1) step(LD, '0);
    end
    exp_q.push_back(model(md, mdt, mr, ctl));
    step(SHR | DONE, ctl ? (SHR | DONE) : 6'b0);
  endtask
  always @(negedge clk) begin
    if (bus.product_valid) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_valid: got product %h with no pending result", bus.product);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("product", {8'h0, bus.product}, {8'h0, e.p});
        chk("product_t", {8'h0, bus.product_t}, {8'h0, e.pt});
        chk("valid_t", {15'h0, bus.product_valid_t}, {15'h0, e.vt});
      end
    end
  end
  initial begin
    {bus.multiplicand, bus.multiplicand_t, bus.multiplier, bus.multiplier_t} = '0;
    {bus.mdld, bus.mrld, bus.rsclear, bus.rsload, bus.rsshr, bus.productDone} = '0;
    {bus.mdld_t, bus.mrld_t, bus.rsclear_t, bus.rsload_t, bus.rsshr_t, bus.productDone_t} = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_product", {8'h0, bus.product}, 16'h0);
    chk("rst_product_t", {8'h0, bus.product_t}, 16'h0);
    chk("rst_mr", {8'h0, bus.multiplierReg, bus.multiplierReg_t}, 16'h0);
    chk("rst_valid", {14'h0, bus.product_valid, bus.product_valid_t}, 16'h0);
    run_mult(3, 0, 5, 0, 1'b0);
    step('0, '0);
    chk("t1_product", {8'h0, bus.product}, 16'h000F);
    chk("t1_valid_pulse", {15'h0, bus.product_valid}, 16'h0);
    run_mult(15, 0, 15, 0, 1'b0);
    run_mult(9, 0, 0, 0, 1'b0);
    run_mult(5, 1, 3, 0, 1'b0);
    chk("t3_product_t", {8'h0, bus.product_t}, 16'h003F);
    bus.multiplicand = 4'd6;
    bus.multiplicand_t = 4'd0;
    bus.multiplier = 4'd7;
    bus.multiplier_t = 4'd0;
    step(MDLD | MRLD | CLR, MRLD);
    chk("t4_mr_t_forced", {12'h0, bus.multiplierReg_t}, 16'h000F);
    chk("t4_product_t_clean", {8'h0, bus.product_t}, 16'h0);
    run_mult(6, 0, 7, 0, 1'b0);
    run_mult(11, 0, 13, 0, 1'b1);
    bus.multiplicand = 4'hF;
    bus.multiplicand_t = 4'h1;
    step(MDLD | CLR, '0);
    step(LD, '0);
    step(LD, '0);
    chk("t5_pre_rs", {8'h0, bus.product}, 16'h00E0);
    chk("t5_pre_rs_t", {8'h0, bus.product_t}, 16'h00F0);
    step(CLR | LD | SHR, '0);
    chk("t5_clear_wins", {8'h0, bus.product}, 16'h0);
    chk("t5_clear_wins_t", {8'h0, bus.product_t}, 16'h0);
    bus.multiplicand = 4'd7;
    bus.multiplicand_t = 4'd3;
    bus.multiplier = 4'd15;
    bus.multiplier_t = 4'd5;
    step(MDLD | MRLD | CLR, '0);
    step(SHR, '0);
    step(LD, '0);
    step(SHR, '0);
    step(LD, '0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t6_product", {8'h0, bus.product}, 16'h0);
    chk("t6_product_t", {8'h0, bus.product_t}, 16'h0);
    chk("t6_mr", {8'h0, bus.multiplierReg, bus.multiplierReg_t}, 16'h0);
    run_mult(2, 0, 6, 0, 1'b0);
    step('0, '0);
    chk("t6_product_after", {8'h0, bus.product}, 16'h000C);
    for (int i = 0; i < 24; i++) begin
      int md, mdt, mr, mrt;
      md = int'($urandom_range(0, 15));
      mr = int'($urandom_range(0, 15));
      mdt = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : 0;
      mrt = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : 0;
      run_mult(md, mdt, mr, mrt, $urandom_range(0, 7) == 0);
    end
    repeat (3) step('0, '0);
    chk("drain", 16'(exp_q.size()), 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
